regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the dual-issue successor core.
- NUM_RD read ports, NUM_WR write ports, x0 hardwired to zero, same-cycle write-to-read bypass.
- Integrated per-register pending-write scoreboard. Decode uses it to detect RAW hazards; writeback releases entries.
- Sits between decode (read/alloc) and writeback (write/release).

Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of architectural registers; power of two, ≥2.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports.
- CNT_W, 2, width of the per-register pending counter.
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NUM_RD*XLEN  read data per port; combinational.
- rbusy  out  NUM_RD  1 = register read on port i has a pending write.
- we  in  NUM_WR  write enable per write port.
- waddr  in  NUM_WR*AW  write addresses.
- wdata  in  NUM_WR*XLEN  write data.
- wrel  in  NUM_WR  1 = this write also releases one pending count on waddr.
- alloc_v  in  NUM_WR  allocate a pending write for alloc_addr (issue of an instruction with rd).
- alloc_addr  in  NUM_WR*AW  allocation addresses.
- flush  in  1  clear all pending counts; array contents are untouched.
- alloc_err  out  1  sticky; set on allocation to a saturated counter or release from a zero counter.

Behaviour:
Reset:
- rst=1 at an edge zeroes every array entry, every pending counter and alloc_err.
- rst dominates we, alloc_v and flush in the same cycle.
- rdata reads 0 and rbusy reads 0 for all ports while the array is in reset state.

Reads (combinational, zero latency), per port i:
- raddr==0 -> rdata=0, rbusy=0, regardless of writes.
- Otherwise, if any write port j has we[j]=1 and waddr[j]==raddr, rdata=wdata of the highest such j (bypass).
- Otherwise rdata = array[raddr].

Writes (one-cycle latency into the array):
- At the edge, array[waddr[j]] <= wdata[j] for each j with we[j]=1 and waddr[j]!=0.
- Writes to x0 are discarded.
- Two ports writing the same address: the higher index wins, matching the bypass priority.

Scoreboard:
- Each register r≠0 has a counter cnt[r] of CNT_W bits. cnt[0] is constantly 0.
- Per edge: inc = number of j with alloc_v[j] && alloc_addr[j]==r; dec = number of j with we[j] && wrel[j] && waddr[j]==r.
- Next state: cnt <= cnt + inc − dec, computed in CNT_W+2 bits.
- If the result is < 0, clamp to 0 and set alloc_err.
- If the result is > 2^CNT_W−1, clamp to max and set alloc_err.
- Simultaneous alloc and release on the same register net out; no error if the result is in range.
- flush=1: all cnt <= 0, and that cycle's alloc_v is ignored; wrel is also ignored. flush does not set alloc_err.
- rbusy[i] = (cnt[raddr[i]] != 0), using the registered value only. No bypass of this cycle's alloc/release; decode already accounts for same-cycle issue.
- alloc_err clears only on rst.

Decomposition:
- Shared package rf_pkg: XLEN, NREG, AW defaults, the x0 index constant, and a helper function extracting slice i of a packed bus.
- One natural sub-module: rf_pend_cnt, a single saturating up/down counter with inputs inc, dec, flush and outputs busy, err.
- Instantiate rf_pend_cnt NREG−1 times in a generate loop. The array and bypass muxes stay in regfile_mp.

Test Plan:
1. rst=1 for 2 cycles, then read ports 0–3 at x1, x5, x31, x0 -> all rdata=0, rbusy=0, alloc_err=0.
2. Bypass: we[0]=1, waddr[0]=7, wdata[0]=0xDEAD_BEEF_0000_0001, raddr[0]=7 in the same cycle -> rdata[0] equals the new value combinationally and still equals it next cycle with we=0.
3. Write conflict: we=2'b11, both waddr=3, wdata0=0x11, wdata1=0x22 -> same-cycle rdata=0x22; array[3]=0x22 afterwards. A write to x0 of 0xFF -> x0 still reads 0.
4. Scoreboard: alloc_v[0] to x9 twice in consecutive cycles -> rbusy(x9)=1. Two writebacks with wrel=1 -> rbusy stays 1 after the first and is 0 after the second. Alloc and release of x9 in the same cycle with cnt=1 -> cnt remains 1.
5. Saturation: CNT_W=2, four allocations to x4 -> cnt=3 and alloc_err=1 (sticky). wrel to x6 with cnt=0 also sets alloc_err; cnt stays 0.
6. flush with alloc_v to x2 in the same cycle -> all rbusy=0 next cycle, x2 not busy. Array data unchanged: x3 still reads 0x22. rst mid-stream -> everything back to 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   X0                  : index of the hardwired-zero register
//   slice_base()        : bit offset of slice i in a packed bus of w-bit fields
package rf_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned X0       = 0;

  function automatic int unsigned slice_base(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/rf_pend_cnt.sv
// Saturating up/down pending-write counter for one architectural register.
//   clk, rst : clock, synchronous active-high reset
//   inc, dec : number of allocations / releases this cycle
//   flush    : clear the count; inc/dec ignored, never flags an error
//   busy     : registered count is non-zero
//   err      : this cycle's update underflowed or overflowed (combinational pulse)
module rf_pend_cnt #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned IW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] inc,
  input  logic [IW-1:0] dec,
  input  logic          flush,
  output logic          busy,
  output logic          err
);

  // Two guard bits: one for carry past the max, one for sign on underflow.
  localparam int unsigned SW = ((CNT_W > IW) ? CNT_W : IW) + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [SW-1:0] sum;

  always_comb begin
    sum   = $signed(SW'(cnt_q)) + $signed(SW'(inc)) - $signed(SW'(dec));
    cnt_d = cnt_q;
    err   = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else if (sum < 0) begin
      cnt_d = '0;
      err   = 1'b1;
    end else if (sum > $signed(CNT_MAX)) begin
      cnt_d = '1;
      err   = 1'b1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = |cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
//   clk, rst          : clock, synchronous active-high reset
//   raddr/rdata/rbusy : NUM_RD combinational read ports with write bypass and busy flag
//   we/waddr/wdata    : NUM_WR write ports (higher index wins on conflict)
//   wrel              : write also releases one pending count on waddr
//   alloc_v/alloc_addr: NUM_WR pending-write allocations
//   flush             : clear all pending counts (array untouched)
//   alloc_err         : sticky scoreboard over/underflow flag
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREG   = NREG_DEF,
  parameter  int unsigned NUM_RD = 4,
  parameter  int unsigned NUM_WR = 2,
  parameter  int unsigned CNT_W  = 2,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic [NUM_RD-1:0]      rbusy,
  input  logic [NUM_WR-1:0]      we,
  input  logic [NUM_WR*AW-1:0]   waddr,
  input  logic [NUM_WR*XLEN-1:0] wdata,
  input  logic [NUM_WR-1:0]      wrel,
  input  logic [NUM_WR-1:0]      alloc_v,
  input  logic [NUM_WR*AW-1:0]   alloc_addr,
  input  logic                   flush,
  output logic                   alloc_err
);

  localparam int unsigned IW = $clog2(NUM_WR + 1);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            alloc_err_q, alloc_err_d;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] cnt_err;

  // Array update: ascending port order lets the higher index win.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (we[j] && waddr[slice_base(j, AW) +: AW] != AW'(X0))
        mem_d[waddr[slice_base(j, AW) +: AW]] = wdata[slice_base(j, XLEN) +: XLEN];
    end
  end

  // Reads: array value, overridden by same-cycle writes, forced to 0 for x0.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      ra = raddr[slice_base(i, AW) +: AW];
      rv = mem_q[ra];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (we[j] && waddr[slice_base(j, AW) +: AW] == ra)
          rv = wdata[slice_base(j, XLEN) +: XLEN];
      end
      if (ra == AW'(X0)) rv = '0;
      rdata[slice_base(i, XLEN) +: XLEN] = rv;
      rbusy[i] = busy[ra];
    end
  end

  assign busy[X0]    = 1'b0;
  assign cnt_err[X0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic [IW-1:0] inc_n, dec_n;

    always_comb begin
      inc_n = '0;
      dec_n = '0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (alloc_v[j] && alloc_addr[slice_base(j, AW) +: AW] == AW'(r))
          inc_n = inc_n + IW'(1);
        if (we[j] && wrel[j] && waddr[slice_base(j, AW) +: AW] == AW'(r))
          dec_n = dec_n + IW'(1);
      end
    end

    rf_pend_cnt #(
      .CNT_W (CNT_W),
      .IW    (IW)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc_n),
      .dec   (dec_n),
      .flush (flush),
      .busy  (busy[r]),
      .err   (cnt_err[r])
    );
  end

  assign alloc_err_d = alloc_err_q | (|cnt_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      alloc_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  assign alloc_err = alloc_err_q;

endmodule
